// File: rtl/mult_unit.sv
// mult_unit: multi-cycle 32/64-bit multiply unit for the Execute stage.
// Operands are latched on acceptance, the product is formed from the latched
// copies, and long results leave through one write port as a lo slot then a
// hi slot. All data outputs are registered; MultBusy is decoded from state.
module mult_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int REGW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StartE,
  input  logic              StallE,
  input  logic [2:0]        MultControlE,
  input  logic              SetFlagsE,
  input  logic [WIDTH-1:0]  SrcAE,
  input  logic [WIDTH-1:0]  SrcBE,
  input  logic [WIDTH-1:0]  AccLoE,
  input  logic [WIDTH-1:0]  AccHiE,
  input  logic [REGW-1:0]   RdLoE,
  input  logic [REGW-1:0]   RdHiE,
  input  logic [1:0]        PrevFlagsE,
  output logic              MultBusy,
  output logic              ResValid,
  output logic [WIDTH-1:0]  Result,
  output logic [REGW-1:0]   ResWA3,
  output logic [3:0]        MultFlags,
  output logic              FlagsValid
);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("mult_unit: STAGES must be in the range 1..8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_WRLO = 2'd2,
    S_WRHI = 2'd3
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(STAGES - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              latch_en;

  // Operation context captured at acceptance.
  logic [WIDTH-1:0]  a_q, b_q, acclo_q, acchi_q;
  logic [2:0]        op_q;
  logic [REGW-1:0]   rdlo_q, rdhi_q;
  logic              setf_q;
  logic [1:0]        cv_q;

  // Registered outputs and their next values.
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [REGW-1:0]   wa_q, wa_d;
  logic [3:0]        flags_q, flags_d;
  logic              fvalid_q, fvalid_d;

  // Arithmetic intermediates.
  logic              is_long, is_signed, long_acc, is_mla;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc_wide, full;
  logic [WIDTH-1:0]  short_sum;
  logic              flag_n, flag_z;

  // Decode the latched opcode; codes 010/011 fall through as plain MUL.
  always_comb begin
    is_long   = op_q[2];
    is_signed = op_q[2] & op_q[1];
    long_acc  = op_q[2] & op_q[0];
    is_mla    = (op_q == 3'b001);
  end

  // Form the full result and N/Z from the latched operands only.
  always_comb begin
    if (is_signed) begin
      ext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      ext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end else begin
      ext_a = {{WIDTH{1'b0}}, a_q};
      ext_b = {{WIDTH{1'b0}}, b_q};
    end
    prod = ext_a * ext_b;
    if (long_acc) begin
      acc_wide = {acchi_q, acclo_q};
    end else begin
      acc_wide = {(2*WIDTH){1'b0}};
    end
    short_sum = prod[WIDTH-1:0] + (is_mla ? acclo_q : {WIDTH{1'b0}});
    if (is_long) begin
      full   = prod + acc_wide;
      flag_n = full[2*WIDTH-1];
      flag_z = (full == {(2*WIDTH){1'b0}});
    end else begin
      full   = {{WIDTH{1'b0}}, short_sum};
      flag_n = short_sum[WIDTH-1];
      flag_z = (short_sum == {WIDTH{1'b0}});
    end
  end

  // Next-state logic: accept, count down the latency, then issue write slots.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (StartE && !StallE) begin
          state_d  = S_CALC;
          cnt_d    = CNT_INIT;
          latch_en = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (!StallE) begin
          if (cnt_q == 3'd0) begin
            state_d = is_long ? S_WRLO : S_WRHI;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else begin
          state_d = S_CALC;
        end
      end
      S_WRLO: begin
        if (!StallE) begin
          state_d = S_WRHI;
        end else begin
          state_d = S_WRLO;
        end
      end
      S_WRHI: begin
        if (!StallE) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WRHI;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered; a held state repeats its slot.
  always_comb begin
    valid_d  = 1'b0;
    result_d = {WIDTH{1'b0}};
    wa_d     = {REGW{1'b0}};
    flags_d  = 4'b0000;
    fvalid_d = 1'b0;
    case (state_d)
      S_WRLO: begin
        valid_d  = 1'b1;
        result_d = full[WIDTH-1:0];
        wa_d     = rdlo_q;
      end
      S_WRHI: begin
        valid_d  = 1'b1;
        result_d = is_long ? full[2*WIDTH-1:WIDTH] : full[WIDTH-1:0];
        wa_d     = rdhi_q;
        flags_d  = {flag_n, flag_z, cv_q};
        fvalid_d = setf_q;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      valid_q  <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      wa_q     <= {REGW{1'b0}};
      flags_q  <= 4'b0000;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      wa_q     <= wa_d;
      flags_q  <= flags_d;
      fvalid_q <= fvalid_d;
    end
  end

  // Operation context, loaded only when a request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acclo_q <= {WIDTH{1'b0}};
      acchi_q <= {WIDTH{1'b0}};
      op_q    <= 3'b000;
      rdlo_q  <= {REGW{1'b0}};
      rdhi_q  <= {REGW{1'b0}};
      setf_q  <= 1'b0;
      cv_q    <= 2'b00;
    end else if (latch_en) begin
      a_q     <= SrcAE;
      b_q     <= SrcBE;
      acclo_q <= AccLoE;
      acchi_q <= AccHiE;
      op_q    <= MultControlE;
      rdlo_q  <= RdLoE;
      rdhi_q  <= RdHiE;
      setf_q  <= SetFlagsE;
      cv_q    <= PrevFlagsE;
    end
  end

  assign MultBusy   = (state_q != S_IDLE);
  assign ResValid   = valid_q;
  assign Result     = result_q;
  assign ResWA3     = wa_q;
  assign MultFlags  = flags_q;
  assign FlagsValid = fvalid_q;

endmodule

// File: tb/tb_mult_unit.sv
// Testbench for mult_unit: directed scenarios plus randomized operations,
// each checked against a plain-arithmetic reference model.
module tb_mult_unit;
  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        reset, StartE, StallE, SetFlagsE;
  logic [2:0]  MultControlE;
  logic [31:0] SrcAE, SrcBE, AccLoE, AccHiE;
  logic [4:0]  RdLoE, RdHiE;
  logic [1:0]  PrevFlagsE;
  logic        MultBusy, ResValid, FlagsValid;
  logic [31:0] Result;
  logic [4:0]  ResWA3;
  logic [3:0]  MultFlags;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  mult_unit #(.WIDTH(32), .STAGES(STAGES), .REGW(5)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .StallE(StallE),
    .MultControlE(MultControlE), .SetFlagsE(SetFlagsE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .AccLoE(AccLoE), .AccHiE(AccHiE),
    .RdLoE(RdLoE), .RdHiE(RdHiE), .PrevFlagsE(PrevFlagsE),
    .MultBusy(MultBusy), .ResValid(ResValid), .Result(Result),
    .ResWA3(ResWA3), .MultFlags(MultFlags), .FlagsValid(FlagsValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result as a 64-bit value (short ops use the low 32 bits).
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, alo, ahi);
    logic [63:0] r;
    longint sp;
    sp = longint'(signed'(a)) * longint'(signed'(b));
    case (op)
      3'b001:  r = {32'd0, 32'(a * b + alo)};
      3'b100:  r = {32'd0, a} * {32'd0, b};
      3'b101:  r = {32'd0, a} * {32'd0, b} + {ahi, alo};
      3'b110:  r = 64'(sp);
      3'b111:  r = 64'(sp) + {ahi, alo};
      default: r = {32'd0, 32'(a * b)};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble_inputs();
    SrcAE = $urandom; SrcBE = $urandom; AccLoE = $urandom; AccHiE = $urandom;
    RdLoE = 5'($urandom); RdHiE = 5'($urandom); PrevFlagsE = 2'($urandom);
    MultControlE = 3'($urandom); SetFlagsE = 1'($urandom);
  endtask

  // Issue one op and check every slot, its timing and the busy window.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, b, alo, ahi,
                       input logic [4:0] rlo, rhi, input logic sf, input logic [1:0] pf,
                       input int lo_stall, input bit poke);
    logic [63:0] r;
    logic [3:0]  fl;
    bit lng, lo_done;
    int busy_n, wr_n, first_c, stl, extra;
    r   = model(op, a, b, alo, ahi);
    lng = op[2];
    fl  = {lng ? r[63] : r[31], lng ? (r == 64'd0) : (r[31:0] == 32'd0), pf};
    MultControlE = op; SrcAE = a; SrcBE = b; AccLoE = alo; AccHiE = ahi;
    RdLoE = rlo; RdHiE = rhi; SetFlagsE = sf; PrevFlagsE = pf;
    StartE = 1'b1; StallE = 1'b0;
    @(posedge clk); #1;
    StartE = 1'b0;
    scramble_inputs();
    busy_n = 0; wr_n = 0; first_c = -1; stl = lo_stall; lo_done = 1'b0;
    for (int c = 0; c < 64 && MultBusy === 1'b1; c++) begin
      busy_n++;
      StartE = (poke && c == 0) ? 1'b1 : 1'b0;
      if (ResValid === 1'b1) begin
        if (first_c < 0) first_c = c;
        wr_n++;
        if (lng && !lo_done) begin
          chk("lo_data", Result, r[31:0]);
          chk("lo_addr", ResWA3, rlo);
          chk("lo_fvalid", FlagsValid, 1'b0);
          if (stl > 0) begin
            StallE = 1'b1; stl--;
          end else begin
            StallE = 1'b0; lo_done = 1'b1;
          end
        end else begin
          chk("hi_data", Result, lng ? r[63:32] : r[31:0]);
          chk("hi_addr", ResWA3, rhi);
          chk("hi_fvalid", FlagsValid, sf);
          if (sf) chk("hi_flags", MultFlags, fl);
          StallE = 1'b0;
        end
      end else begin
        chk("calc_result_zero", Result, 32'd0);
        chk("calc_fvalid", FlagsValid, 1'b0);
      end
      @(posedge clk); #1;
    end
    StartE = 1'b0; StallE = 1'b0;
    chk("busy_len", busy_n, STAGES + 1 + int'(lng) + lo_stall);
    chk("first_write", first_c, STAGES);
    chk("num_writes", wr_n, 1 + int'(lng) + lo_stall);
    if (poke) begin
      extra = 0;
      for (int c = 0; c < 2 * STAGES + 4; c++) begin
        if (ResValid === 1'b1 || MultBusy === 1'b1) extra++;
        @(posedge clk); #1;
      end
      chk("poke_ignored", extra, 0);
    end
  endtask

  // Start a long op, reset it in CALC or WRLO, and confirm no hi write follows.
  task automatic do_reset(input bit at_wrlo);
    int waited, extra;
    MultControlE = 3'b110; SrcAE = 32'hFFFF_FFFE; SrcBE = 32'd3;
    RdLoE = 5'd4; RdHiE = 5'd5; SetFlagsE = 1'b1; PrevFlagsE = 2'b00;
    StartE = 1'b1; StallE = 1'b0;
    @(posedge clk); #1;
    StartE = 1'b0;
    if (at_wrlo) begin
      waited = 0;
      while (ResValid !== 1'b1 && waited < 20) begin
        @(posedge clk); #1; waited++;
      end
      chk("rst_reach_wrlo", ResWA3, 5'd4);
    end else begin
      chk("rst_in_calc", MultBusy, 1'b1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_busy", MultBusy, 1'b0);
    chk("rst_valid", ResValid, 1'b0);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (ResValid === 1'b1 || MultBusy === 1'b1) extra++;
      @(posedge clk); #1;
    end
    chk("rst_no_hi", extra, 0);
  endtask

  initial begin
    logic [2:0] op;
    int st;
    reset = 1'b1; StartE = 1'b0; StallE = 1'b0; SetFlagsE = 1'b0;
    MultControlE = 3'b000; SrcAE = 32'd0; SrcBE = 32'd0; AccLoE = 32'd0; AccHiE = 32'd0;
    RdLoE = 5'd0; RdHiE = 5'd0; PrevFlagsE = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", MultBusy, 1'b0);
    chk("reset_valid", ResValid, 1'b0);
    chk("reset_result", Result, 32'd0);
    chk("reset_wa", ResWA3, 5'd0);
    chk("reset_flags", MultFlags, 4'd0);
    chk("reset_fvalid", FlagsValid, 1'b0);
    reset = 1'b0;

    // MUL 7*6 -> r3
    do_op(3'b000, 32'd7, 32'd6, 32'd0, 32'd0, 5'd0, 5'd3, 1'b0, 2'b00, 0, 1'b0);
    // SMULLS -2*3
    do_op(3'b110, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 5'd4, 5'd5, 1'b1, 2'b00, 0, 1'b0);
    // UMLAL wrap
    do_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd6, 5'd7, 1'b1, 2'b01, 0, 1'b0);
    // SMULLS with two stall cycles in the lo slot
    do_op(3'b110, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 5'd4, 5'd5, 1'b1, 2'b00, 2, 1'b0);
    // Reset in CALC and in WRLO, each followed by an immediate MUL
    do_reset(1'b0);
    do_op(3'b000, 32'd9, 32'd9, 32'd0, 32'd0, 5'd0, 5'd1, 1'b0, 2'b00, 0, 1'b0);
    do_reset(1'b1);
    do_op(3'b001, 32'd3, 32'd4, 32'd5, 32'd0, 5'd0, 5'd2, 1'b1, 2'b11, 0, 1'b0);
    // MULS zero with C passthrough, StartE poked during CALC
    do_op(3'b000, 32'd0, 32'd5, 32'd0, 32'd0, 5'd0, 5'd8, 1'b1, 2'b10, 0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom);
      st = op[2] ? $urandom_range(0, 2) : 0;
      do_op(op, pick(), pick(), pick(), pick(), 5'($urandom), 5'($urandom),
            1'($urandom), 2'($urandom), st, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
